// File: rtl/seven_segment_reader_if.sv
// rtl/seven_segment_reader_if.sv - display-side and capture-side signals of the seven-segment reader (optional SEG_READER_ERRCNT_EN adds err_count)
interface seven_segment_reader_if;
  logic [0:6]  seg_n;
  logic [3:0]  an_n;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  dvalid;
  logic        frame_done;
  logic        err;
`ifdef SEG_READER_ERRCNT_EN
  logic [7:0]  err_count;

  modport master (
    output seg_n, an_n, err_clr,
    input  digits, dvalid, frame_done, err, err_count
  );

  modport slave (
    input  seg_n, an_n, err_clr,
    output digits, dvalid, frame_done, err, err_count
  );
`else
  modport master (
    output seg_n, an_n, err_clr,
    input  digits, dvalid, frame_done, err
  );

  modport slave (
    input  seg_n, an_n, err_clr,
    output digits, dvalid, frame_done, err
  );
`endif
endinterface

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - samples a multiplexed 4-digit seven-segment display and captures stable digit codes (optional SEG_READER_ERRCNT_EN)
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  seven_segment_reader_if.slave bus
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [0:6]  seg_q, prev_seg_q;
  logic [3:0]  an_q, prev_an_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        held_q;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dvalid_q, dvalid_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;

  logic        sample_valid;
  logic        capture;
  logic [1:0]  cap_idx;
  logic [3:0]  cap_code;
  logic        cap_bad;
  logic [3:0]  seen_or;

  // Pattern to digit code; 4'hE with bad=1 for anything not in the table
  function automatic logic [4:0] decode(input logic [0:6] pat);
    case (pat)
      7'b0000001: decode = {1'b0, 4'h0};
      7'b1001111: decode = {1'b0, 4'h1};
      7'b0010010: decode = {1'b0, 4'h2};
      7'b0000110: decode = {1'b0, 4'h3};
      7'b1001100: decode = {1'b0, 4'h4};
      7'b0100100: decode = {1'b0, 4'h5};
      7'b0100000: decode = {1'b0, 4'h6};
      7'b0001111: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0001100: decode = {1'b0, 4'h9};
      7'b1111111: decode = {1'b0, 4'hF};
      default:    decode = {1'b1, 4'hE};
    endcase
  endfunction

  // Input stage plus a one-deep history used for the equality test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= 7'b1111111;
      an_q       <= 4'b1111;
      prev_seg_q <= 7'b1111111;
      prev_an_q  <= 4'b1111;
    end else begin
      seg_q      <= bus.seg_n;
      an_q       <= bus.an_n;
      prev_seg_q <= seg_q;
      prev_an_q  <= an_q;
    end
  end

  assign sample_valid = $onehot(~an_q);

  // Run-length of identical valid samples, saturating at STABLE_CYCLES
  always_comb begin
    cnt_d = 8'd0;
    if (sample_valid) begin
      if (seg_q == prev_seg_q && an_q == prev_an_q)
        cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 8'd1;
      else
        cnt_d = 8'd1;
    end
  end

  // held_q marks that the current dwell has already been captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      held_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= (cnt_q == STABLE_C);
    end
  end

  // The sample that completed the run sits in the prev_* registers
  assign capture = (cnt_q == STABLE_C) && !held_q;
  assign {cap_bad, cap_code} = decode(prev_seg_q);

  // Selected digit index from the single low anode bit
  always_comb begin
    cap_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!prev_an_q[i]) cap_idx = 2'(i);
  end

  assign seen_or = seen_q | (capture ? (4'b0001 << cap_idx) : 4'b0000);

  // Capture results, frame tracking and sticky error
  always_comb begin
    digits_d = digits_q;
    dvalid_d = dvalid_q;
    seen_d   = seen_or;
    frame_d  = 1'b0;
    err_d    = err_q;
    if (capture) begin
      digits_d[{cap_idx, 2'b00} +: 4] = cap_code;
      dvalid_d[cap_idx]               = 1'b1;
    end
    if (seen_or == 4'hF) begin
      frame_d = 1'b1;
      seen_d  = 4'h0;
    end
    if (capture && cap_bad)
      err_d = 1'b1;
    else if (bus.err_clr)
      err_d = 1'b0;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= 16'hFFFF;
      dvalid_q <= 4'h0;
      seen_q   <= 4'h0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dvalid_q <= dvalid_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.frame_done = frame_q;
  assign bus.err        = err_q;

`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Error counter: increment beats clear, saturates at 255
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (capture && cap_bad)
      err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    else if (bus.err_clr)
      err_cnt_d = 8'd0;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`endif

endmodule
